main_job_sched: RTL

//  Two-requester round-robin scheduler and sequencer for the shared `main` datapath.
//  - Arbitrates between requesters 0 and 1.
//  - Drives the datapath controls x/on/start for the winning requester.
//  - Tracks the datapath's `active` flag until the operation finishes.
//  - Returns y/s/b/regime on a shared result bus, with a one-hot done pulse to the owner.
//  - Sits between the requesting logic and the single `main` instance.

---
 rtl/main_job_sched.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/main_job_sched.sv
`timescale 1ns/1ps
// main_job_sched
// Two-requester round-robin scheduler and sequencer for the shared `main`
// datapath. Picks an owner, presents its operand/mode to the datapath, pulses
// start, follows the datapath's active flag to completion (or aborts on a
// timeout), then returns the captured result with a one-hot done pulse.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req[1:0]            level requests, held until the owner's done pulse
//   x0/x1, on0/on1      operand and mode per requester
//   grant[1:0]          one-hot owner while a job is in flight, 0 otherwise
//   done[1:0]           one-cycle one-hot completion pulse to the owner
//   res_y/s/b/regime    captured datapath result, valid while done != 0
//   res_err             1 when the job was aborted by timeout
//   m_x, m_on, m_start  controls to the datapath
//   m_y/s/b/regime      datapath result inputs
//   m_active            datapath busy flag
module main_job_sched #(
   parameter int TIMEOUT = 255,
   parameter int TW      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [7:0] x0,
   input  logic [7:0] x1,
   input  logic [1:0] on0,
   input  logic [1:0] on1,
   output logic [1:0] grant,
   output logic [1:0] done,
   output logic [7:0] res_y,
   output logic [2:0] res_s,
   output logic       res_b,
   output logic [1:0] res_regime,
   output logic       res_err,
   output logic [7:0] m_x,
   output logic [1:0] m_on,
   output logic       m_start,
   input  logic [7:0] m_y,
   input  logic [2:0] m_s,
   input  logic       m_b,
   input  logic [1:0] m_regime,
   input  logic       m_active
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACT, BUSY, DONE} state_t;

   localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          rrLast_q, rrLast_d;
   logic [7:0]    mX_q, mX_d;
   logic [1:0]    mOn_q, mOn_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    resY_q, resY_d;
   logic [2:0]    resS_q, resS_d;
   logic          resB_q, resB_d;
   logic [1:0]    resRegime_q, resRegime_d;
   logic          resErr_q, resErr_d;
   logic          pickOwner;
   logic          abortJob;
   logic [1:0]    ownerOneHot;

   // State and datapath-facing registers. rrLast resets to 1 so requester 0
   // wins the very first contention.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         rrLast_q    <= 1'b1;
         mX_q        <= '0;
         mOn_q       <= '0;
         timer_q     <= '0;
         resY_q      <= '0;
         resS_q      <= '0;
         resB_q      <= 1'b0;
         resRegime_q <= '0;
         resErr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rrLast_q    <= rrLast_d;
         mX_q        <= mX_d;
         mOn_q       <= mOn_d;
         timer_q     <= timer_d;
         resY_q      <= resY_d;
         resS_q      <= resS_d;
         resB_q      <= resB_d;
         resRegime_q <= resRegime_d;
         resErr_q    <= resErr_d;
      end
   end

   // Next-state logic. The timer stops at the TIMEOUT compare (abort), so it
   // can never wrap. Operands are latched only in IDLE, which is what makes
   // requester input changes mid-job invisible to the datapath.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rrLast_d    = rrLast_q;
      mX_d        = mX_q;
      mOn_d       = mOn_q;
      timer_d     = timer_q;
      resY_d      = resY_q;
      resS_d      = resS_q;
      resB_d      = resB_q;
      resRegime_d = resRegime_q;
      resErr_d    = resErr_q;
      abortJob    = 1'b0;
      // Sole requester wins; on contention the one not served last wins.
      pickOwner   = (req == 2'b11) ? ~rrLast_q : req[1];

      case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               owner_d = pickOwner;
               mX_d    = pickOwner ? x1 : x0;
               mOn_d   = pickOwner ? on1 : on0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            timer_d = '0;
            state_d = WAIT_ACT;
         end
         WAIT_ACT: begin
            if (m_active) begin
               timer_d = '0;
               state_d = BUSY;
            end else if (timer_q == TIMEOUT_T) begin
               abortJob = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         BUSY: begin
            if (!m_active) begin
               resY_d      = m_y;
               resS_d      = m_s;
               resB_d      = m_b;
               resRegime_d = m_regime;
               resErr_d    = 1'b0;
               state_d     = DONE;
            end else if (timer_q == TIMEOUT_T) begin
               abortJob = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         DONE: begin
            rrLast_d = owner_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (abortJob) begin
         resY_d      = '0;
         resS_d      = '0;
         resB_d      = 1'b0;
         resRegime_d = '0;
         resErr_d    = 1'b1;
         state_d     = DONE;
      end
   end

   // Grant covers the in-flight states only; it is already low during DONE.
   assign ownerOneHot = owner_q ? 2'b10 : 2'b01;
   assign grant       = ((state_q == ISSUE) || (state_q == WAIT_ACT) || (state_q == BUSY))
                        ? ownerOneHot : 2'b00;
   assign done        = (state_q == DONE) ? ownerOneHot : 2'b00;
   assign m_start     = (state_q == ISSUE);
   assign m_x         = mX_q;
   assign m_on        = mOn_q;
   assign res_y       = resY_q;
   assign res_s       = resS_q;
   assign res_b       = resB_q;
   assign res_regime  = resRegime_q;
   assign res_err     = resErr_q;

endmodule
